// File: rtl/adc_pipe_pkg.sv
// rtl/adc_pipe_pkg.sv - shared types and widths for the ADC pipeline sequencer
package adc_pipe_pkg;

  localparam int BURST_W  = 8;
  localparam int PERIOD_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_NOV1 = 3'd2,
    ST_PH2  = 3'd3,
    ST_NOV2 = 3'd4
  } phase_state_t;

endpackage

// File: rtl/adc_pipe_phase_gen.sv
// rtl/adc_pipe_phase_gen.sv - PH1/NOV1/PH2/NOV2 timer with registered phase and encoder clocks
module adc_pipe_phase_gen
  import adc_pipe_pkg::*;
#(
  parameter int PHASE_CYCLES = 2,
  parameter int NOV_CYCLES   = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_last,
  output logic o_phi1,
  output logic o_phi2,
  output logic o_enc_clk,
  output logic o_enc_clk2,
  output logic o_period_end,
  output logic o_busy
);

  localparam logic [3:0] PH_LAST  = 4'(PHASE_CYCLES - 1);
  localparam logic [3:0] NOV_LAST = 4'(NOV_CYCLES - 1);

  phase_state_t r_state;
  phase_state_t w_state_next;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_next;
  logic         w_period_end;
  logic         r_phi1;
  logic         r_phi2;
  logic         r_enc_clk;
  logic         r_enc_clk2;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 4'd1;
    w_period_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (i_start) w_state_next = ST_PH1;
      end
      ST_PH1: if (r_cnt == PH_LAST) begin
        w_state_next = ST_NOV1;
        w_cnt_next   = '0;
      end
      ST_NOV1: if (r_cnt == NOV_LAST) begin
        w_state_next = ST_PH2;
        w_cnt_next   = '0;
      end
      ST_PH2: if (r_cnt == PH_LAST) begin
        w_state_next = ST_NOV2;
        w_cnt_next   = '0;
      end
      ST_NOV2: if (r_cnt == NOV_LAST) begin
        w_period_end = 1'b1;
        w_cnt_next   = '0;
        w_state_next = i_last ? ST_IDLE : ST_PH1;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state without a combinational path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_phi1     <= 1'b0;
      r_phi2     <= 1'b0;
      r_enc_clk  <= 1'b0;
      r_enc_clk2 <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_phi1     <= (w_state_next == ST_PH1);
      r_phi2     <= (w_state_next == ST_PH2);
      r_enc_clk  <= (w_state_next == ST_NOV1) && (r_state != ST_NOV1);
      r_enc_clk2 <= (w_state_next == ST_NOV2) && (r_state != ST_NOV2);
    end
  end

  assign o_phi1       = r_phi1;
  assign o_phi2       = r_phi2;
  assign o_enc_clk    = r_enc_clk;
  assign o_enc_clk2   = r_enc_clk2;
  assign o_period_end = w_period_end;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: rtl/adc_pipe_sequencer.sv
// rtl/adc_pipe_sequencer.sv - burst/flush period counting and result handshake for a pipelined ADC
module adc_pipe_sequencer
  import adc_pipe_pkg::*;
#(
  parameter int NUM_BITS     = 3,
  parameter int PHASE_CYCLES = 2,
  parameter int NOV_CYCLES   = 1,
  parameter int LAT_PERIODS  = 2
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [BURST_W-1:0]  burst_len_i,
  output logic                phi1_o,
  output logic                phi2_o,
  output logic                enc_clk_o,
  output logic                enc_clk2_o,
  input  logic [NUM_BITS-1:0] d_i,
  output logic [NUM_BITS-1:0] data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

  logic                w_busy;
  logic                w_period_end;
  logic                w_start;
  logic                w_last_sample;
  logic                w_last;
  logic                w_capture;
  logic [BURST_W-1:0]  r_burst_len;
  logic [PERIOD_W-1:0] r_period;
  logic                r_sampling;
  logic [2:0]          r_flush_cnt;
  logic                r_stop_req;
  logic [NUM_BITS-1:0] r_data;
  logic                r_valid;
  logic                r_overrun;
  logic                r_done;

  adc_pipe_phase_gen #(
    .PHASE_CYCLES(PHASE_CYCLES),
    .NOV_CYCLES  (NOV_CYCLES)
  ) u_phase_gen (
    .i_clk       (clock_i),
    .i_rst_n     (reset_ni),
    .i_start     (w_start),
    .i_last      (w_last),
    .o_phi1      (phi1_o),
    .o_phi2      (phi2_o),
    .o_enc_clk   (enc_clk_o),
    .o_enc_clk2  (enc_clk2_o),
    .o_period_end(w_period_end),
    .o_busy      (w_busy)
  );

  assign w_start       = start_i && !w_busy;
  // A stop arriving in the final cycle of a period still ends that period.
  assign w_last_sample = r_sampling &&
                         (r_stop_req || stop_i ||
                          ((r_burst_len != '0) && (r_period == {1'b0, r_burst_len})));
  assign w_last        = !r_sampling && (r_flush_cnt == 3'd1);
  assign w_capture     = w_period_end && (r_period > PERIOD_W'(LAT_PERIODS));

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_burst_len <= '0;
      r_period    <= '0;
      r_sampling  <= 1'b0;
      r_flush_cnt <= '0;
      r_stop_req  <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_period_end && w_last;
      if (w_start) begin
        r_burst_len <= burst_len_i;
        r_period    <= PERIOD_W'(1);
        r_sampling  <= 1'b1;
        r_flush_cnt <= '0;
        r_stop_req  <= 1'b0;
        r_overrun   <= 1'b0;
      end else begin
        if (stop_i && w_busy) r_stop_req <= 1'b1;
        if (w_period_end) begin
          // Saturate so a long continuous run never wraps back below the capture threshold.
          if (r_period != '1) r_period <= r_period + PERIOD_W'(1);
          if (w_last_sample) begin
            r_sampling  <= 1'b0;
            r_flush_cnt <= 3'(LAT_PERIODS);
          end else if (!r_sampling) begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
      end
      if (w_capture) begin
        r_data  <= d_i;
        r_valid <= 1'b1;
        if (r_valid && !ready_i) r_overrun <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign busy_o    = w_busy;
  assign done_o    = r_done;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_adc_pipe_sequencer.sv
// tb/tb_adc_pipe_sequencer.sv - directed table-driven bench for adc_pipe_sequencer
module tb_adc_pipe_sequencer;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       start_i;
  logic       stop_i;
  logic [7:0] burst_len_i;
  logic       phi1_o, phi2_o, enc_clk_o, enc_clk2_o;
  logic [2:0] d_i;
  logic [2:0] data_o;
  logic       valid_o, ready_i, busy_o, done_o, overrun_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_phi1, n_phi2, n_enc, n_enc2, n_valid;
  int n_overlap = 0;

  typedef struct {
    int         cyc;
    logic [3:0] ph;
    logic       busy;
    logic       valid;
    logic       done;
    logic [2:0] data;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  adc_pipe_sequencer #(
    .NUM_BITS(3), .PHASE_CYCLES(2), .NOV_CYCLES(1), .LAT_PERIODS(2)
  ) dut (
    .clock_i    (clk),
    .reset_ni   (reset_ni),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .burst_len_i(burst_len_i),
    .phi1_o     (phi1_o),
    .phi2_o     (phi2_o),
    .enc_clk_o  (enc_clk_o),
    .enc_clk2_o (enc_clk2_o),
    .d_i        (d_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overrun_o  (overrun_o)
  );

  always @(negedge clk) begin
    assert (!(phi1_o && phi2_o)) else n_overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [10:0] all_outs();
    return {phi1_o, phi2_o, enc_clk_o, enc_clk2_o, data_o, valid_o, busy_o, done_o, overrun_o};
  endfunction

  task automatic sample();
    n_phi1  += int'(phi1_o);
    n_phi2  += int'(phi2_o);
    n_enc   += int'(enc_clk_o);
    n_enc2  += int'(enc_clk2_o);
    n_valid += int'(valid_o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    d_i = 3'(cyc);
    sample();
  endtask

  task automatic do_start(input logic [7:0] len);
    start_i = 1'b1;
    burst_len_i = len;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc = 0;
    d_i = 3'd0;
    n_phi1 = 0; n_phi2 = 0; n_enc = 0; n_enc2 = 0; n_valid = 0;
    sample();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_done(input int limit);
    while (!done_o && cyc < limit) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{0,  4'b1000, 1'b1, 1'b0, 1'b0, 3'd0},
      '{1,  4'b1000, 1'b1, 1'b0, 1'b0, 3'd0},
      '{2,  4'b0010, 1'b1, 1'b0, 1'b0, 3'd0},
      '{3,  4'b0100, 1'b1, 1'b0, 1'b0, 3'd0},
      '{4,  4'b0100, 1'b1, 1'b0, 1'b0, 3'd0},
      '{5,  4'b0001, 1'b1, 1'b0, 1'b0, 3'd0},
      '{6,  4'b1000, 1'b1, 1'b0, 1'b0, 3'd0},
      '{17, 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0},
      '{18, 4'b1000, 1'b1, 1'b1, 1'b0, 3'd1},
      '{19, 4'b1000, 1'b1, 1'b0, 1'b0, 3'd1},
      '{24, 4'b1000, 1'b1, 1'b1, 1'b0, 3'd7},
      '{29, 4'b0001, 1'b1, 1'b0, 1'b0, 3'd7},
      '{30, 4'b0000, 1'b0, 1'b1, 1'b1, 3'd5},
      '{31, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd5}
    };

    reset_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; burst_len_i = 8'd0;
    ready_i = 1'b1; d_i = 3'd0;
    #22;
    check("reset_outputs", 32'(all_outs()), 32'd0);
    reset_ni = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(all_outs()), 32'd0);

    // Burst of 3, consumer always ready
    do_start(8'd3);
    for (int i = 0; i < 14; i++) begin
      run_to(vecs[i].cyc);
      check("b3_phases", 32'({phi1_o, phi2_o, enc_clk_o, enc_clk2_o}), 32'(vecs[i].ph));
      check("b3_busy",   32'(busy_o),  32'(vecs[i].busy));
      check("b3_valid",  32'(valid_o), 32'(vecs[i].valid));
      check("b3_done",   32'(done_o),  32'(vecs[i].done));
      check("b3_data",   32'(data_o),  32'(vecs[i].data));
    end
    check("b3_phi1_cycles", 32'(n_phi1), 32'd10);
    check("b3_phi2_cycles", 32'(n_phi2), 32'd10);
    check("b3_enc_pulses",  32'(n_enc),  32'd5);
    check("b3_enc2_pulses", 32'(n_enc2), 32'd5);
    check("b3_results",     32'(n_valid), 32'd3);

    // Continuous mode, ignored restart while busy, stop in period 4
    do_start(8'd0);
    run_to(10);
    start_i = 1'b1; burst_len_i = 8'd1;
    tick();
    start_i = 1'b0;
    run_to(20);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_done(200);
    check("cont_done_cycle", 32'(cyc), 32'd36);
    check("cont_results",    32'(n_valid), 32'd4);
    check("cont_idle",       32'(busy_o), 32'd0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    tick();
    check("stop_in_idle", 32'({busy_o, phi1_o, phi2_o, done_o}), 32'd0);

    // Burst of 2 with consumer stalled: overrun on second capture
    ready_i = 1'b0;
    do_start(8'd2);
    run_to(18);
    check("ovr_first_valid", 32'(valid_o), 32'd1);
    check("ovr_first_data",  32'(data_o), 32'd1);
    check("ovr_first_flag",  32'(overrun_o), 32'd0);
    run_to(24);
    check("ovr_second_data", 32'(data_o), 32'd7);
    check("ovr_flag_set",    32'(overrun_o), 32'd1);
    check("ovr_done",        32'(done_o), 32'd1);
    tick();
    check("ovr_sticky",      32'(overrun_o), 32'd1);

    // Restart clears overrun; capture with ready in the same cycle keeps valid
    do_start(8'd1);
    check("restart_clears_ovr", 32'(overrun_o), 32'd0);
    check("restart_keeps_valid", 32'(valid_o), 32'd1);
    run_to(17);
    ready_i = 1'b1;
    tick();
    check("cap_ready_valid", 32'(valid_o), 32'd1);
    check("cap_ready_data",  32'(data_o), 32'd1);
    check("cap_ready_ovr",   32'(overrun_o), 32'd0);
    check("cap_ready_done",  32'(done_o), 32'd1);
    tick();
    check("ready_clears_valid", 32'(valid_o), 32'd0);

    // Asynchronous reset mid-burst
    do_start(8'd3);
    run_to(8);
    check("pre_reset_enc", 32'(enc_clk_o), 32'd1);
    tick();
    check("pre_reset_phi2", 32'(phi2_o), 32'd1);
    reset_ni = 1'b0;
    #1;
    check("async_reset_outs", 32'(all_outs()), 32'd0);
    tick();
    tick();
    check("held_reset_outs", 32'(all_outs()), 32'd0);
    reset_ni = 1'b1;
    tick();
    tick();
    tick();
    check("post_reset_idle", 32'(all_outs()), 32'd0);
    do_start(8'd1);
    wait_done(100);
    check("post_reset_done_cycle", 32'(cyc), 32'd18);
    check("post_reset_valid", 32'(valid_o), 32'd1);
    check("post_reset_data",  32'(data_o), 32'd1);

    check("phi_overlap", 32'(n_overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_pipe_sequencer.md
ADC_PIPE_SEQUENCER -- requirements
Module: adc_pipe_sequencer

Interface
REQ-001 Parameter NUM_BITS, default 3, width of the encoder result d_i/data_o.
REQ-002 Parameter PHASE_CYCLES, default 2, clock cycles per active phase (phi1/phi2); legal range 1..15.
REQ-003 Parameter NOV_CYCLES, default 1, non-overlap gap cycles between phases; legal range 1..15.
REQ-004 Parameter LAT_PERIODS, default 2, encoder latency in conversion periods; legal range 1..7.
REQ-005 Ports:
- clock_i  in  1  single system clock, all logic on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle conversion request
- stop_i  in  1  end sampling request
- burst_len_i  in  8  conversions per burst; 0 = continuous
- phi1_o  out  1  sample phase to the stages
- phi2_o  out  1  amplify/hold phase to the stages
- enc_clk_o  out  1  encoder clock pulse, first edge
- enc_clk2_o  out  1  encoder clock pulse, second edge
- d_i  in  NUM_BITS  encoder output
- data_o  out  NUM_BITS  captured result
- valid_o  out  1  data_o holds an unconsumed result
- ready_i  in  1  consumer accepts data_o
- busy_o  out  1  sequencer not IDLE
- done_o  out  1  one-cycle pulse at burst end
- overrun_o  out  1  sticky: result overwritten unread

Function
REQ-006 FSM states IDLE, PH1, NOV1, PH2, NOV2, with the period T = 2*PHASE_CYCLES + 2*NOV_CYCLES.
REQ-007 PH1 and PH2 last PHASE_CYCLES; NOV1 and NOV2 last NOV_CYCLES; transitions PH1->NOV1->PH2->NOV2->PH1 or IDLE.
REQ-008 phi1_o=1 only in PH1 and phi2_o=1 only in PH2; they are registered and never both high.
REQ-009 enc_clk_o pulses for the first cycle of NOV1; enc_clk2_o pulses for the first cycle of NOV2.
REQ-010 IDLE + start_i: latch burst_len_i, clear the period counter and overrun_o, enter PH1 next cycle; busy_o=1 from that cycle.
REQ-011 start_i while busy_o=1 is ignored; stop_i in IDLE is ignored; start_i wins if both arrive in IDLE.
REQ-012 Sampling periods: burst mode runs exactly burst_len periods; continuous mode samples until stop_i.
REQ-013 stop_i in any non-IDLE state ends sampling after the current period completes; this applies to both modes and is remembered if it is a one-cycle pulse.
REQ-014 After the last sampling period, LAT_PERIODS flush periods run with identical phase timing.
REQ-015 Capture occurs on the last cycle of NOV2 of period j (1-based) iff j > LAT_PERIODS: data_o<=d_i and valid_o<=1.
REQ-016 Each burst therefore yields one result per sampling period, with the first result at cycle LAT_PERIODS*T + T after start.
REQ-017 valid_o is cleared when ready_i=1 and valid_o=1, unless a capture occurs in the same cycle, in which case new data loads and valid_o stays 1.
REQ-018 A capture with valid_o=1 and ready_i=0 overwrites data_o and sets overrun_o, which holds until the next accepted start_i.
REQ-019 At the end of the final flush period, done_o pulses 1 cycle, FSM returns to IDLE, busy_o=0 next cycle, and valid_o/data_o are retained.
REQ-020 The period counter is 9 bits and saturates in continuous mode, so that it does not wrap into capture gating.

Reset
REQ-021 reset_ni=0 asynchronously forces IDLE and sets every output to 0, including data_o; this applies mid-burst, with no flush and no done_o.
REQ-022 After reset deassertion, the block stays in IDLE until start_i.

Structure
REQ-023 The state enum, the 8-bit burst width, and the 9-bit counter width are placed in shared package adc_pipe_pkg.
REQ-024 One sub-module, adc_pipe_phase_gen, contains the PH1/NOV1/PH2/NOV2 timer and the phi/enc_clk outputs; the top contains burst/flush counting and the output handshake.

Verification (PHASE_CYCLES=2, NOV_CYCLES=1, LAT_PERIODS=2, T=6)
REQ-025 With start_i, burst_len_i=3 and ready_i=1, the bench sees phi1 2cy, gap 1, phi2 2cy, gap 1, repeating; 3 captures at cycles 18, 24 and 30 after start; done_o at cycle 30.
REQ-026 With burst_len_i=0 and stop_i pulsed at cycle 20: sampling ends after period 4, 2 flush periods follow, 4 results are produced, and done_o pulses at cycle 36.
REQ-027 With burst_len_i=2 and ready_i=0 throughout: the 2nd capture sets overrun_o=1, data_o equals the 2nd d_i, and the next start_i clears overrun_o.
REQ-028 Capture and ready_i=1 in the same cycle leave valid_o=1 with new data; ready_i alone clears valid_o the next cycle.
REQ-029 reset_ni low at cycle 9 of a burst: all outputs are 0 immediately, IDLE, no done_o; a later start_i runs a normal burst.
REQ-030 start_i during busy and stop_i in IDLE cause no change; phi1_o&phi2_o is never 1 (assertion).
